// File: rtl/param_insert_sort.sv
// Streaming insertion sorter: systolic slot array kept ordered on every insert, then drained under ready/valid.
// Define ISORT_DESCEND_EN for descending order (empty slots still rank last).

module param_insert_sort_slot #(
  parameter int KEY_W = 25,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins,
  input  logic             pop,
  input  logic             lt,
  input  logic             lt_prev,
  input  logic [KEY_W-1:0] new_key,
  input  logic [TAG_W-1:0] new_tag,
  input  logic             prev_vld,
  input  logic [KEY_W-1:0] prev_key,
  input  logic [TAG_W-1:0] prev_tag,
  input  logic             next_vld,
  input  logic [KEY_W-1:0] next_key,
  input  logic [TAG_W-1:0] next_tag,
  output logic             vld,
  output logic [KEY_W-1:0] key,
  output logic [TAG_W-1:0] tag
);
  // lt is monotonic across the array, so the first slot with lt set is the insert point
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      key <= '0;
      tag <= '0;
    end else if (ins) begin
      if (lt && !lt_prev) begin
        vld <= 1'b1;
        key <= new_key;
        tag <= new_tag;
      end else if (lt) begin
        vld <= prev_vld;
        key <= prev_key;
        tag <= prev_tag;
      end
    end else if (pop) begin
      vld <= next_vld;
      key <= next_key;
      tag <= next_tag;
    end
  end
endmodule

module param_insert_sort #(
  parameter int DEPTH = 32,
  parameter int KEY_W = 25,
  parameter int TAG_W = 5,
  localparam int LW = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_key,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KEY_W-1:0] out_key,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_last,
  output logic             busy,
  output logic [LW-1:0]    level
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  state_t state, state_nxt;

  logic [DEPTH-1:0]            vld, lt;
  logic [DEPTH-1:0][KEY_W-1:0] key;
  logic [DEPTH-1:0][TAG_W-1:0] tag;

  logic accept, pop, close;
  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign close  = accept && (in_last || level == LW'(DEPTH-1));

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic             lt_prev, p_vld, n_vld;
    logic [KEY_W-1:0] p_key, n_key;
    logic [TAG_W-1:0] p_tag, n_tag;

`ifdef ISORT_DESCEND_EN
    assign lt[i] = !vld[i] || (in_key > key[i]);
`else
    assign lt[i] = !vld[i] || (in_key < key[i]);
`endif

    if (i == 0) begin : g_head
      assign lt_prev = 1'b0;
      assign p_vld   = 1'b0;
      assign p_key   = '0;
      assign p_tag   = '0;
    end else begin : g_body
      assign lt_prev = lt[i-1];
      assign p_vld   = vld[i-1];
      assign p_key   = key[i-1];
      assign p_tag   = tag[i-1];
    end

    if (i == DEPTH-1) begin : g_tail
      assign n_vld = 1'b0;
      assign n_key = '0;
      assign n_tag = '0;
    end else begin : g_link
      assign n_vld = vld[i+1];
      assign n_key = key[i+1];
      assign n_tag = tag[i+1];
    end

    param_insert_sort_slot #(.KEY_W(KEY_W), .TAG_W(TAG_W)) u_slot (
      .clk(clk), .rst(rst), .ins(accept), .pop(pop), .lt(lt[i]), .lt_prev(lt_prev),
      .new_key(in_key), .new_tag(in_tag),
      .prev_vld(p_vld), .prev_key(p_key), .prev_tag(p_tag),
      .next_vld(n_vld), .next_key(n_key), .next_tag(n_tag),
      .vld(vld[i]), .key(key[i]), .tag(tag[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = close ? DRAIN : LOAD;
      LOAD:    if (close) state_nxt = DRAIN;
      DRAIN:   if (pop && level == LW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != DRAIN);
    out_valid = (state == DRAIN);
    busy      = (state != IDLE);
    out_last  = out_valid && (level == LW'(1));
    out_key   = out_valid ? key[0] : '0;
    out_tag   = out_valid ? tag[0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst)         level <= '0;
    else if (accept) level <= level + LW'(1);
    else if (pop)    level <= level - LW'(1);
  end
endmodule

// File: tb/tb_param_insert_sort.sv
// Scoreboard bench for param_insert_sort: a DEPTH=4 and a DEPTH=32 instance share stimulus, selected by sel.
module tb_param_insert_sort;
  localparam int KW = 25;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst, sel, in_valid, in_last, out_ready;
  logic [KW-1:0] in_key;
  logic [TW-1:0] in_tag;

  logic          a_ir, a_ov, a_ol, a_busy, b_ir, b_ov, b_ol, b_busy;
  logic [KW-1:0] a_key, b_key;
  logic [TW-1:0] a_tag, b_tag;
  logic [2:0]    a_lvl;
  logic [5:0]    b_lvl;

  logic          o_ir, o_ov, o_ol, o_busy;
  logic [KW-1:0] o_key;
  logic [TW-1:0] o_tag;
  logic [5:0]    o_lvl;

  always #5 clk = ~clk;

  param_insert_sort #(.DEPTH(4), .KEY_W(KW), .TAG_W(TW)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(a_ir),
    .in_key(in_key), .in_tag(in_tag), .in_last(in_last),
    .out_valid(a_ov), .out_ready(out_ready), .out_key(a_key), .out_tag(a_tag),
    .out_last(a_ol), .busy(a_busy), .level(a_lvl)
  );

  param_insert_sort #(.DEPTH(32), .KEY_W(KW), .TAG_W(TW)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(b_ir),
    .in_key(in_key), .in_tag(in_tag), .in_last(in_last),
    .out_valid(b_ov), .out_ready(out_ready), .out_key(b_key), .out_tag(b_tag),
    .out_last(b_ol), .busy(b_busy), .level(b_lvl)
  );

  assign o_ir   = sel ? b_ir   : a_ir;
  assign o_ov   = sel ? b_ov   : a_ov;
  assign o_ol   = sel ? b_ol   : a_ol;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_key  = sel ? b_key  : a_key;
  assign o_tag  = sel ? b_tag  : a_tag;
  assign o_lvl  = sel ? b_lvl  : {3'b000, a_lvl};

  typedef struct {
    logic [KW-1:0] key;
    logic [TW-1:0] tag;
    logic          last;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit precedes(input logic [KW-1:0] a, input logic [KW-1:0] b);
`ifdef ISORT_DESCEND_EN
    return a > b;
`else
    return a < b;
`endif
  endfunction

  task automatic send_beat(input logic [KW-1:0] k, input logic [TW-1:0] t, input logic l);
    int cyc = 0;
    in_valid = 1'b1; in_key = k; in_tag = t; in_last = l;
    while (!o_ir && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    n_checks++;
    if (o_ir !== 1'b1) begin
      n_fail++;
      $display("FAIL send_beat_timeout in_ready=%0b required 1", o_ir);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Expected order by repeated stable selection (earliest arrival wins ties)
  task automatic send_frame(input logic [KW-1:0] k[4], input logic [TW-1:0] t[4],
                            input int n, input logic last_flag);
    bit used[4] = '{default: 1'b0};
    for (int j = 0; j < n; j++) begin
      int best = -1;
      exp_t e;
      for (int i = 0; i < n; i++)
        if (!used[i] && (best < 0 || precedes(k[i], k[best]))) best = i;
      used[best] = 1'b1;
      e.key = k[best]; e.tag = t[best]; e.last = (j == n-1);
      q.push_back(e);
    end
    for (int i = 0; i < n; i++) send_beat(k[i], t[i], last_flag && (i == n-1));
  endtask

  task automatic drain(input bit bp, input string name);
    int cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      n_checks++;
      if (32'(o_lvl) !== q.size()) begin
        n_fail++; $display("FAIL %s_level got %0d expected %0d", name, o_lvl, q.size());
      end
      n_checks++;
      if (o_ov !== 1'b1) begin
        n_fail++; $display("FAIL %s_out_valid got %0b expected 1", name, o_ov);
      end
      n_checks++;
      if (o_key !== q[0].key || o_tag !== q[0].tag || o_ol !== q[0].last) begin
        n_fail++;
        $display("FAIL %s_data got key=%0h tag=%0d last=%0b expected key=%0h tag=%0d last=%0b",
                 name, o_key, o_tag, o_ol, q[0].key, q[0].tag, q[0].last);
      end
      if (out_ready) void'(q.pop_front());
      @(posedge clk); #1; cyc++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL %s_drain_timeout remaining=%0d expected 0", name, q.size());
      q.delete();
    end
    n_checks++;
    if (o_ov !== 1'b0 || o_ir !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_return_idle got valid=%0b ready=%0b busy=%0b expected 0 1 0", name, o_ov, o_ir, o_busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_key = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (o_lvl !== 6'd0 || o_ir !== 1'b1 || o_ov !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl got lvl=%0d ready=%0b valid=%0b busy=%0b expected 0 1 0 0", o_lvl, o_ir, o_ov, o_busy);
    end
    n_checks++;
    if (o_key !== '0 || o_tag !== '0 || o_ol !== 1'b0) begin
      n_fail++; $display("FAIL reset_data got key=%0h tag=%0d last=%0b expected 0 0 0", o_key, o_tag, o_ol);
    end
  endtask

  task automatic test_basic;
    send_frame('{25'd9, 25'd3, 25'd7, 25'd1}, '{5'd0, 5'd1, 5'd2, 5'd3}, 4, 1'b1);
    n_checks++;
    if (o_ov !== 1'b1 || o_ir !== 1'b0 || o_busy !== 1'b1 || o_lvl !== 6'd4) begin
      n_fail++; $display("FAIL basic_latency got valid=%0b ready=%0b busy=%0b lvl=%0d expected 1 0 1 4", o_ov, o_ir, o_busy, o_lvl);
    end
    drain(1'b0, "basic");
  endtask

  task automatic test_stable;
    send_frame('{25'd5, 25'd5, 25'd2, 25'd5}, '{5'd0, 5'd1, 5'd2, 5'd3}, 4, 1'b1);
    drain(1'b0, "stable");
  endtask

  task automatic test_short_frame;
    sel = 1'b1;
    send_frame('{25'h1FFFFFF, 25'h0, 25'h1FFFFFF, 25'h0}, '{5'd4, 5'd5, 5'd6, 5'd0}, 3, 1'b1);
    n_checks++;
    if (o_lvl !== 6'd3 || o_ov !== 1'b1) begin
      n_fail++; $display("FAIL short_close got lvl=%0d valid=%0b expected 3 1", o_lvl, o_ov);
    end
    drain(1'b0, "short");
    sel = 1'b0;
  endtask

  task automatic test_auto_close;
    exp_t e;
    send_frame('{25'd20, 25'd10, 25'd40, 25'd30}, '{5'd1, 5'd2, 5'd3, 5'd4}, 4, 1'b0);
    n_checks++;
    if (o_ir !== 1'b0 || o_ov !== 1'b1) begin
      n_fail++; $display("FAIL auto_close got ready=%0b valid=%0b expected 0 1", o_ir, o_ov);
    end
    in_valid = 1'b1; in_key = 25'd42; in_tag = 5'd9; in_last = 1'b1;
    drain(1'b0, "auto");
    n_checks++;
    if (o_lvl !== 6'd0) begin
      n_fail++; $display("FAIL auto_no_accept_in_drain got lvl=%0d expected 0", o_lvl);
    end
    e.key = 25'd42; e.tag = 5'd9; e.last = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain(1'b0, "auto_fifth");
  endtask

  task automatic test_back_pressure;
    send_frame('{25'd6, 25'd1, 25'd4, 25'd2}, '{5'd7, 5'd8, 5'd9, 5'd10}, 4, 1'b1);
    drain(1'b1, "bp");
  endtask

  task automatic test_mid_reset;
    send_beat(25'd8, 5'd0, 1'b0);
    send_beat(25'd4, 5'd1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (o_lvl !== 6'd0 || o_ir !== 1'b1 || o_ov !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got lvl=%0d ready=%0b valid=%0b busy=%0b expected 0 1 0 0", o_lvl, o_ir, o_ov, o_busy);
    end
    send_frame('{25'd7, 25'd2, 25'd0, 25'd0}, '{5'd1, 5'd2, 5'd0, 5'd0}, 2, 1'b1);
    drain(1'b0, "post_reset");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stable();
    test_short_frame();
    test_auto_close();
    test_back_pressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/param_insert_sort.md
Name: param_insert_sort

Overview:
Parametrised streaming insertion sorter, the successor to the fixed 32-entry colour/total sorter. Accepts a frame of up to DEPTH {key, tag} beats, one per cycle. Each beat is inserted into a systolic register array kept ordered at all times. The block then drains the frame in sorted order under ready/valid back-pressure. It sits between the divider (which produces key = {color, total}) and the image-output stage (which consumes the tag = image index).

Parameters:
DEPTH, 32, max entries per frame; legal range >= 2
KEY_W, 25, sort key width; compared as unsigned
TAG_W, 5, payload (image index) width; carried alongside the key, never compared

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_key  in  KEY_W  sort key
in_tag  in  TAG_W  payload tag
in_last  in  1  marks final beat of frame
out_valid  out  1  sorted beat valid
out_ready  in  1  downstream accepts beat
out_key  out  KEY_W  sorted key
out_tag  out  TAG_W  tag travelling with out_key
out_last  out  1  final sorted beat of frame
busy  out  1  high in LOAD or DRAIN
level  out  $clog2(DEPTH+1)  entries currently held

Behaviour:
- Storage: DEPTH slots, each holding {vld, key, tag}. An empty slot (vld=0) compares as +infinity, so no key value is reserved as a sentinel; all-ones keys are legal data.
- Reset (rst=1 at a clock edge, from any state, including mid-frame): state=IDLE, all slot vld=0, level=0, in_ready=1, out_valid=0, out_last=0, busy=0, out_key=0, out_tag=0. Any partial frame is discarded.
- States: IDLE, LOAD, DRAIN.
- Accept occurs when in_valid && in_ready.
- IDLE: in_ready=1. On accept, insert the beat, level=1, go to LOAD. If in_last is set on that beat, go straight to DRAIN (single-entry frame).
- LOAD: in_ready=1. Each accept inserts the beat and increments level.
  - The frame closes on the accept that carries in_last=1, or on the accept that makes level=DEPTH, whichever comes first.
  - On close: next state is DRAIN and in_ready deasserts the following cycle.
- Insertion rule:
  - Position p = lowest index i where slot[i].vld=0 or in_key < slot[i].key (strict less-than).
  - Slots p..DEPTH-2 move to p+1..DEPTH-1; the new beat is written to slot p.
  - Strict compare makes the sort stable: equal keys leave in arrival order.
  - Single cycle: DEPTH parallel comparators plus a shift mux. No multi-cycle insert.
- Ordering: ascending; slot[0] always holds the minimum.
- DRAIN:
  - in_ready=0; out_valid=1 starting the cycle after close (close-to-first-output latency is 1 clock).
  - out_key/out_tag = slot[0].key/tag; out_last = (level==1).
  - On out_valid && out_ready: every slot shifts down by one, slot[DEPTH-1].vld=0, level decrements.
  - Holding out_ready=0 stalls the output with data stable.
  - After the handshake with out_last=1: out_valid=0 the next cycle, state=IDLE, in_ready=1.
- No bubble between frames beyond that one IDLE cycle. The input is never accepted during DRAIN, so overflow is impossible.
- in_valid while in_ready=0 is ignored; upstream holds the beat.
- level saturates at DEPTH by construction.
- busy=1 in LOAD and DRAIN.

Optional Feature:
ISORT_DESCEND_EN
- Defined: descending order. Insertion test becomes in_key > slot[i].key (strict, still stable); slot[0] holds the maximum. Empty slots still rank last.
- Undefined: ascending order as above.
- Ports and timing are identical in both builds.

Test Plan:
- DEPTH=4. Feed keys 9,3,7,1 (tags 0..3), in_last on the 4th beat, out_ready=1. Expect out keys 1,3,7,9 with tags 3,1,2,0; out_last on key 9; first out_valid 1 cycle after the 4th accept.
- Stability: keys 5,5,2,5 (tags 0,1,2,3). Expect keys 2,5,5,5 with tags 2,0,1,3.
- Short frame: DEPTH=32, 3 beats 0x1FFFFFF,0,0x1FFFFFF with in_last on the 3rd. Expect 0 then both all-ones entries in arrival order; level=3 at close; all-ones data is not lost.
- Auto-close: DEPTH=4, 4 beats with in_last=0. in_ready drops after the 4th accept and out_valid rises; a 5th in_valid is not accepted until the drain completes.
- Back-pressure: during DRAIN toggle out_ready 1,0,0,1. out_key/out_tag hold stable while out_ready=0; level decrements only on handshakes.
- Mid-frame reset: assert rst after 2 of 4 beats. Next cycle: level=0, in_ready=1, out_valid=0, busy=0. A new frame of 7,2 (in_last on 2) drains as 2,7.
- ISORT_DESCEND_EN build: keys 9,3,7,1 drain as 9,7,3,1.
